// File: rtl/ledger_line_drawer.sv
// Ledger-line glyph renderer: reads one 8-row glyph from the ROM and writes each row
// across a run of byte tiles in the packed monochrome frame buffer, clipping at the edges.
module ledger_line_drawer #(
    parameter int COLS = 80,
    parameter int ROWS = 480
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_code,
    input  logic [6:0]  req_x,
    input  logic [8:0]  req_y,
    input  logic [2:0]  req_len,
    output logic [4:0]  rom_addr,
    input  logic [7:0]  rom_data,
    output logic        fb_wr_valid,
    input  logic        fb_wr_ready,
    output logic [15:0] fb_wr_addr,
    output logic [7:0]  fb_wr_data,
    output logic        busy,
    output logic        done
);

    localparam logic [7:0]  COLS_B   = 8'(COLS);
    localparam logic [15:0] COLS_W   = 16'(COLS);
    localparam logic [9:0]  ROWS_B   = 10'(ROWS);
    localparam logic [9:0]  LAST_ROW = 10'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  code_q, code_d;
    logic [6:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic [2:0]  last_tile_q, last_tile_d;
    logic [2:0]  row_q, row_d;
    logic [2:0]  tile_q, tile_d;
    logic [15:0] row_base_q, row_base_d;

    logic [7:0]  room;
    logic [15:0] req_row_base;
    logic [9:0]  cur_row;
    logic        out_of_range;

    // Tiles remaining to the right edge; only meaningful when req_x is on screen.
    assign room         = COLS_B - 8'd1 - {1'b0, req_x};
    assign req_row_base = (COLS == 80) ? (({7'b0, req_y} << 6) + ({7'b0, req_y} << 4))
                                       : ({7'b0, req_y} * COLS_W);
    assign out_of_range = ({1'b0, req_x} >= COLS_B) || ({1'b0, req_y} >= ROWS_B);
    assign cur_row      = {1'b0, y_q} + {7'b0, row_q};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= S_IDLE;
            code_q      <= 2'd0;
            x_q         <= 7'd0;
            y_q         <= 9'd0;
            last_tile_q <= 3'd0;
            row_q       <= 3'd0;
            tile_q      <= 3'd0;
            row_base_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            x_q         <= x_d;
            y_q         <= y_d;
            last_tile_q <= last_tile_d;
            row_q       <= row_d;
            tile_q      <= tile_d;
            row_base_q  <= row_base_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        x_d         = x_q;
        y_d         = y_q;
        last_tile_d = last_tile_q;
        row_d       = row_q;
        tile_d      = tile_q;
        row_base_d  = row_base_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    code_d      = req_code;
                    x_d         = req_x;
                    y_d         = req_y;
                    row_d       = 3'd0;
                    tile_d      = 3'd0;
                    row_base_d  = req_row_base;
                    last_tile_d = (room < {5'b0, req_len}) ? room[2:0] : req_len;
                    state_d     = out_of_range ? S_DONE : S_WRITE;
                end
            end
            S_WRITE: begin
                if (fb_wr_ready) begin
                    if (tile_q != last_tile_q) begin
                        tile_d = tile_q + 3'd1;
                    end else begin
                        tile_d = 3'd0;
                        // Bottom of glyph or bottom of screen ends the request.
                        if (row_q == 3'd7 || cur_row == LAST_ROW) begin
                            state_d = S_DONE;
                        end else begin
                            row_d      = row_q + 3'd1;
                            row_base_d = row_base_q + COLS_W;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign req_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign fb_wr_valid = (state_q == S_WRITE);
    assign rom_addr    = {code_q, (state_q == S_WRITE) ? row_q : 3'b000};
    assign fb_wr_addr  = (state_q == S_WRITE) ? (row_base_q + {9'b0, x_q} + {13'b0, tile_q}) : 16'd0;
    assign fb_wr_data  = rom_data;

endmodule

// File: doc/ledger_line_drawer.md
# ledger_line_drawer

- Renders ledger-line glyphs into the byte-packed monochrome frame buffer. Each buffer byte holds 8 horizontal pixels; one row is 80 bytes (640 px) and there are 480 rows.
- Accepts one draw request per transaction and reads the ledger glyph ROM row by row. Each glyph-ROM row is written across a run of horizontal tiles through a valid/ready write port.
- Sits between the note-placement logic and the frame-buffer write arbiter, acting as the reader of the glyph ROM.

## Interface
Parameters:
- COLS, 80: frame-buffer bytes per row.
- ROWS, 480: frame-buffer pixel rows.

Ports:
- Clk  in  1  system clock; all state on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  draw request present.
- req_ready  out  1  block can accept a request.
- req_code  in  2  glyph code: 0 blank, 1 middle, 2 above, 3 below.
- req_x  in  7  first tile column (byte index within row).
- req_y  in  9  top pixel row of the glyph.
- req_len  in  3  tile count minus 1 (1..8 tiles).
- rom_addr  out  5  glyph-ROM address, {code, row[2:0]}.
- rom_data  in  8  glyph-ROM data; combinational, valid in the same cycle as rom_addr.
- fb_wr_valid  out  1  write present.
- fb_wr_ready  in  1  arbiter accepts write.
- fb_wr_addr  out  16  byte address, (y+row)*80 + x + tile.
- fb_wr_data  out  8  equals rom_data (MSB = leftmost pixel).
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a request completes.

## Operation
- States are IDLE, WRITE and DONE.
- **IDLE**
  - req_ready=1.
  - On req_valid&&req_ready, latch code, x, y and len.
  - Zero row and tile counters; set the row base to y*80 (computed as y<<6 + y<<4, 16-bit).
  - Compute last_tile = min(req_len, COLS-1-req_x).
  - If req_x>=COLS or req_y>=ROWS, go to DONE with no writes; otherwise go to WRITE.
- **WRITE**
  - fb_wr_valid=1; rom_addr={code_q,row}; fb_wr_addr=row_base+x_q+tile; fb_wr_data=rom_data.
  - On fb_wr_ready with tile<last_tile: tile+1.
  - On fb_wr_ready with tile==last_tile: tile=0.
    - If row==7 or y_q+row==ROWS-1, go to DONE.
    - Otherwise row+1 and row_base+80.
  - Without fb_wr_ready, all outputs hold stable. Valid never drops and addr/data never change while stalled.
- **DONE**
  - done=1, req_ready=0; go to IDLE next cycle.
- Write order: row-major (row outer, tile inner), so addresses within a row are consecutive.
- Code 0 writes 0x00 to every tile; this is the erase operation and is a normal draw.
- Horizontal clipping: tiles past column 79 are never written.
- Vertical clipping: rows past 479 are never written, and the request ends early.
- Requests are never queued. req_ready=0 in WRITE and DONE.
- Outside WRITE, rom_addr={code_q,3'b000}.

## Timing
- Reset values: req_ready=1, fb_wr_valid=0, fb_wr_addr=0, rom_addr=0, busy=0, done=0; state IDLE; all counters 0.
- Reset asserted mid-WRITE: fb_wr_valid drops immediately (asynchronously). The pending request is abandoned with no done pulse.
- Accept at edge k: fb_wr_valid is high from cycle k+1.
- With fb_wr_ready tied high, W = 8*(last_tile+1) writes (fewer if vertically clipped) occupy cycles k+1..k+W.
  - done is high in cycle k+W+1.
  - req_ready is high again in cycle k+W+2.
- Out-of-range request: done in cycle k+1, no fb_wr_valid.
- A write transfers on any cycle with fb_wr_valid&&fb_wr_ready.
- Address arithmetic is 16-bit unsigned. The maximum address is 479*80+79=38399, so it never wraps.

## Test plan
- **Basic draw.** code=1, x=10, y=100, len=0, ready high.
  - 8 writes: addrs 8010, 8090, …, 8570.
  - Data is 0x00 except row 4 (addr 8330) = 0xFF.
  - done in cycle 9 after accept.
- **Multi-tile.** code=2, x=0, y=0, len=7.
  - 64 writes; the first 8 are addrs 0..7 with data 0xFF, then addrs 80..87 with 0x00, and so on.
  - done 65 cycles after accept.
- **Backpressure.** code=3, x=5, y=20, len=1; fb_wr_ready toggles 1-0-0-1.
  - addr/data/valid hold during stalls.
  - Exactly 16 transfers; row 7 (addrs 2165, 2166) = 0xFF.
- **Clipping.**
  - x=78, len=7, y=476: writes only cols 78-79, rows 476-479, 8 writes total, last addr 38399.
  - x=80: zero writes, done at k+1.
- **Erase / back-to-back.** code=0 request issued while busy.
  - req_ready=0 until 2 cycles after the final write.
  - The second request then draws 0x00 at all its addresses.
- **Reset mid-operation.** Assert Reset_n=0 after 5 writes.
  - fb_wr_valid=0, req_ready=1 and busy=0 immediately; no done pulse.
  - After release, a new request operates normally.
